i2s_to_pcm_converter: RTL and testbench
=======================================

# i2s_to_pcm_converter

I2S receiver: recovers 24-bit left/right PCM samples from an external I2S stream (bclk, lrclk, s_data) and presents them as parallel words with one-cycle valid strobes in the `clk` domain. It is the receive-side counterpart of the PCM-to-I2S transmitter and sits between the ADC/codec I2S pins and the audio processing pipeline. The external I2S clocks are asynchronous to `clk`, so the block oversamples them (49.152 MHz `clk`, bclk ≤ 6.144 MHz). It also tracks frame lock and flags malformed channel slots.

## Interface
- `DATA_WIDTH`, 24: PCM word width.
- `SYNC_STAGES`, 2: synchronizer flops on bclk, lrclk and s_data (≥2).
- `TIMEOUT_CLKS`, 255: `clk` cycles without a bclk rising edge before lock is dropped.
- `clk` in 1: system clock, 49.152 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `bclk` in 1: I2S bit clock, asynchronous.
- `lrclk` in 1: I2S word select, asynchronous; 0 = left, 1 = right.
- `s_data` in 1: I2S serial data, MSB first, one-bclk delay after each lrclk edge.
- `l_data` out DATA_WIDTH: last received left sample.
- `r_data` out DATA_WIDTH: last received right sample.
- `l_data_valid` out 1: one-cycle strobe, `l_data` updated.
- `r_data_valid` out 1: one-cycle strobe, `r_data` updated.
- `frame_err` out 1: one-cycle strobe, coincident with a valid strobe, when that slot had fewer than DATA_WIDTH bits.
- `locked` out 1: high while in RECEIVE.

## Operation
- bclk, lrclk and s_data each pass through SYNC_STAGES flops. A bclk rising edge is detected from the last two synchronized bclk values, giving a 1-cycle `bclk_rise` pulse. lrclk and s_data are sampled only on `bclk_rise` and stored as `ws_s` and `sd_s`. `ws_prev` holds the previous `ws_s`.
- States:
  - HUNT (reset state): samples are discarded. The first `bclk_rise` with `ws_s != ws_prev` moves to RECEIVE, clears the shift register `sr` and `bit_cnt`, and emits no strobe.
  - RECEIVE, `bclk_rise` with no ws change: if `bit_cnt < DATA_WIDTH`, write `sd_s` into `sr[DATA_WIDTH-1-bit_cnt]`. Increment `bit_cnt`, saturating at 63. Bits beyond DATA_WIDTH in a slot (e.g. 32-bit slots) are ignored.
  - RECEIVE, `bclk_rise` with a ws change: `sd_s` is the final bit of the ending slot and is written under the same rule. Then:
    - If `ws_prev` was 0, load the completed word into `l_data` and pulse `l_data_valid`; otherwise load `r_data` and pulse `r_data_valid`.
    - If `bit_cnt` (counting this bit) < DATA_WIDTH, pulse `frame_err`. The word is left-justified and its missing LSBs are 0.
    - Clear `sr` and `bit_cnt`.
  - Timeout: a counter is cleared on each `bclk_rise` and increments otherwise. When it reaches TIMEOUT_CLKS in any state, go to HUNT and clear `sr`/`bit_cnt`. `l_data`/`r_data` hold their values. A slot cut short by timeout emits no strobe.
- Reset (asserted at any time, including mid-word) forces the following; no strobe is emitted for the interrupted word:
  - all outputs 0;
  - state HUNT;
  - `sr`, `bit_cnt`, timeout counter, `ws_prev` and synchronizers 0.
- `l_data_valid` and `r_data_valid` are never high in the same cycle.

## Timing
- Input-to-`bclk_rise` latency: SYNC_STAGES+1 `clk` cycles.
- Strobes and data update occur 1 cycle after the `bclk_rise` that detects the ws change. The data register and its strobe change in the same cycle.
- `l_data`/`r_data` hold until the next strobe for the same channel.
- `locked` rises 1 cycle after the HUNT→RECEIVE `bclk_rise`. It falls 1 cycle after timeout or immediately on reset.
- Minimum bclk high or low time: 3 `clk` cycles (guaranteed for bclk ≤ 6.144 MHz).

## Test plan
- 64·fs frames (32 bclk per slot), L=0xA5A5A5, R=0x123456, repeated 4 frames → first partial slot discarded; then alternating `l_data`=0xA5A5A5 and `r_data`=0x123456 with single-cycle strobes, `frame_err`=0, `locked`=1.
- 48·fs frames (24-bit slots), L=0x800001, R=0x7FFFFF → exact words; no extra or missing strobes.
- 32·fs frames (16-bit slots), L=0xBEEF → `l_data`=0xBEEF00 with `frame_err` pulsed alongside `l_data_valid`.
- bclk stopped for 300 `clk` cycles mid-slot → `locked` falls and no strobe is emitted. On restart, the first slot is discarded, then correct words resume.
- `reset_n` asserted for 5 cycles mid left slot → all outputs 0. After release, lock is reacquired on the next lrclk edge and the following full slot is decoded correctly.
- bclk at exactly 6.144 MHz, 32-bit slots, random data for 100 frames → all words match the scoreboard.

Source files
------------

// File: rtl/i2s_to_pcm_converter.sv
// I2S receiver: oversamples bclk/lrclk/s_data in the clk domain and recovers
// left/right PCM words with one-cycle strobes, frame lock and short-slot flags.
module i2s_to_pcm_converter #(
  parameter int DATA_WIDTH   = 24,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_CLKS = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  s_data,
  output logic [DATA_WIDTH-1:0] l_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  l_data_valid,
  output logic                  r_data_valid,
  output logic                  frame_err,
  output logic                  locked
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS);
  localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {HUNT, RECEIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   rise_q, rise_d;
  logic                   ws_s_q, ws_s_d;
  logic                   sd_s_q, sd_s_d;
  logic                   ws_prev_q, ws_prev_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]  sr_q, sr_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  l_data_q, l_data_d;
  logic [DATA_WIDTH-1:0]  r_data_q, r_data_d;
  logic                   l_vld_q, l_vld_d;
  logic                   r_vld_q, r_vld_d;
  logic                   ferr_q, ferr_d;

  logic                   bclk_rise;
  logic                   ws_chg;
  logic [DATA_WIDTH-1:0]  word;

  assign bclk_rise = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
  assign ws_chg    = ws_s_q ^ ws_prev_q;
  // Shifting past the LSB yields an all-zero mask, so surplus slot bits drop out.
  assign word      = sr_q | ({DATA_WIDTH{sd_s_q}} & (MSB_ONE >> bit_cnt_q));

  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
    ws_sync_d   = {ws_sync_q[SYNC_STAGES-2:0], lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], s_data};
    bclk_prev_d = bclk_sync_q[SYNC_STAGES-1];
    rise_d      = bclk_rise;
    ws_s_d      = ws_s_q;
    sd_s_d      = sd_s_q;
    ws_prev_d   = ws_prev_q;
    tmo_d       = tmo_q;
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    l_data_d    = l_data_q;
    r_data_d    = r_data_q;
    l_vld_d     = 1'b0;
    r_vld_d     = 1'b0;
    ferr_d      = 1'b0;

    if (bclk_rise) begin
      ws_s_d    = ws_sync_q[SYNC_STAGES-1];
      sd_s_d    = sd_sync_q[SYNC_STAGES-1];
      ws_prev_d = ws_s_q;
      tmo_d     = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end

    // rise_q marks the cycle in which ws_s/sd_s/ws_prev hold the new bit.
    case (state_q)
      HUNT: begin
        if (rise_q && ws_chg) begin
          state_d   = RECEIVE;
          sr_d      = '0;
          bit_cnt_d = '0;
        end
      end
      default: begin
        if (rise_q) begin
          if (ws_chg) begin
            if (!ws_prev_q) begin
              l_data_d = word;
              l_vld_d  = 1'b1;
            end else begin
              r_data_d = word;
              r_vld_d  = 1'b1;
            end
            ferr_d    = (int'(bit_cnt_q) + 1) < DATA_WIDTH;
            sr_d      = '0;
            bit_cnt_d = '0;
          end else begin
            sr_d = word;
            if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
    endcase

    if (tmo_q == TMO_MAX) begin
      state_d   = HUNT;
      sr_d      = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      bclk_sync_q <= '0;
      ws_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      ws_s_q      <= 1'b0;
      sd_s_q      <= 1'b0;
      ws_prev_q   <= 1'b0;
      tmo_q       <= '0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      l_data_q    <= '0;
      r_data_q    <= '0;
      l_vld_q     <= 1'b0;
      r_vld_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      ws_sync_q   <= ws_sync_d;
      sd_sync_q   <= sd_sync_d;
      bclk_prev_q <= bclk_prev_d;
      rise_q      <= rise_d;
      ws_s_q      <= ws_s_d;
      sd_s_q      <= sd_s_d;
      ws_prev_q   <= ws_prev_d;
      tmo_q       <= tmo_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      l_data_q    <= l_data_d;
      r_data_q    <= r_data_d;
      l_vld_q     <= l_vld_d;
      r_vld_q     <= r_vld_d;
      ferr_q      <= ferr_d;
    end
  end

  assign l_data       = l_data_q;
  assign r_data       = r_data_q;
  assign l_data_valid = l_vld_q;
  assign r_data_valid = r_vld_q;
  assign frame_err    = ferr_q;
  assign locked       = (state_q == RECEIVE);

endmodule

// File: tb/tb_i2s_to_pcm_converter.sv
// Directed bench for the I2S receiver: drives framed I2S streams, captures
// strobed words and compares them with hand-derived expected sequences.
module tb_i2s_to_pcm_converter;

  localparam int HALF = 4;  // bclk half period in clk cycles (clk/8 = 6.144 MHz)

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        s_data = 1'b0;
  logic [23:0] l_data, r_data;
  logic        l_data_valid, r_data_valid, frame_err, locked;

  int n_checks = 0;
  int n_fail   = 0;
  int both_cnt = 0, long_cnt = 0, orphan_cnt = 0;
  logic prev_bit = 1'b0;

  logic [24:0] l_q[$], r_q[$], exp_l[$], exp_r[$];
  logic [23:0] rl[100], rr[100];

  i2s_to_pcm_converter #(.DATA_WIDTH(24), .SYNC_STAGES(2), .TIMEOUT_CLKS(255)) dut (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .lrclk(lrclk), .s_data(s_data),
    .l_data(l_data), .r_data(r_data), .l_data_valid(l_data_valid),
    .r_data_valid(r_data_valid), .frame_err(frame_err), .locked(locked)
  );

  always #10 clk = ~clk;

  initial begin : monitor
    logic lp, rp;
    lp = 1'b0;
    rp = 1'b0;
    forever begin
      @(negedge clk);
      if (l_data_valid) l_q.push_back({frame_err, l_data});
      if (r_data_valid) r_q.push_back({frame_err, r_data});
      if (l_data_valid && r_data_valid) both_cnt++;
      if ((l_data_valid && lp) || (r_data_valid && rp)) long_cnt++;
      if (frame_err && !l_data_valid && !r_data_valid) orphan_cnt++;
      lp = l_data_valid;
      rp = r_data_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic seq_bit(input logic [23:0] w, input int k);
    return (k < 24) ? w[23-k] : 1'b0;
  endfunction

  // Data lags word select by one bclk, so each bclk carries the previous sequence bit.
  task automatic send_bit(input logic ws, input logic b);
    lrclk    = ws;
    s_data   = prev_bit;
    prev_bit = b;
    repeat (HALF) @(negedge clk);
    bclk = 1'b1;
    repeat (HALF) @(negedge clk);
    bclk = 1'b0;
  endtask

  task automatic send_slot(input logic ws, input logic [23:0] w, input int from, input int to);
    for (int k = from; k < to; k++) send_bit(ws, seq_bit(w, k));
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r, input int n);
    send_slot(1'b0, l, 0, n);
    send_slot(1'b1, r, 0, n);
  endtask

  task automatic close_and_flush();
    send_bit(1'b0, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    bclk     = 1'b0;
    lrclk    = 1'b0;
    s_data   = 1'b0;
    prev_bit = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_l"}, {8'h0, l_data}, 32'h0);
    check({tag, "_rst_r"}, {8'h0, r_data}, 32'h0);
    check({tag, "_rst_ctl"}, {28'h0, l_data_valid, r_data_valid, frame_err, locked}, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    l_q.delete();
    r_q.delete();
    exp_l.delete();
    exp_r.delete();
  endtask

  task automatic compare(input string tag);
    check({tag, "_lcnt"}, l_q.size(), exp_l.size());
    check({tag, "_rcnt"}, r_q.size(), exp_r.size());
    for (int i = 0; i < l_q.size() && i < exp_l.size(); i++)
      check($sformatf("%s_l%0d", tag, i), {7'h0, l_q[i]}, {7'h0, exp_l[i]});
    for (int i = 0; i < r_q.size() && i < exp_r.size(); i++)
      check($sformatf("%s_r%0d", tag, i), {7'h0, r_q[i]}, {7'h0, exp_r[i]});
  endtask

  initial begin
    // 64fs: first left slot discarded while hunting
    do_reset("t1");
    for (int f = 0; f < 4; f++) begin
      frame(24'hA5A5A5, 24'h123456, 32);
      exp_r.push_back({1'b0, 24'h123456});
      if (f > 0) exp_l.push_back({1'b0, 24'hA5A5A5});
    end
    close_and_flush();
    compare("t1");
    check("t1_locked", {31'h0, locked}, 32'h1);
    check("t1_lhold", {8'h0, l_data}, 32'h00A5A5A5);
    check("t1_rhold", {8'h0, r_data}, 32'h00123456);

    // 48fs: exact 24-bit slots
    do_reset("t2");
    for (int f = 0; f < 3; f++) begin
      frame(24'h800001, 24'h7FFFFF, 24);
      exp_r.push_back({1'b0, 24'h7FFFFF});
      if (f > 0) exp_l.push_back({1'b0, 24'h800001});
    end
    close_and_flush();
    compare("t2");

    // 32fs: short slots, left-justified with frame_err
    do_reset("t3");
    for (int f = 0; f < 3; f++) begin
      frame(24'hBEEF00, 24'hCAFE00, 16);
      exp_r.push_back({1'b1, 24'hCAFE00});
      if (f > 0) exp_l.push_back({1'b1, 24'hBEEF00});
    end
    close_and_flush();
    compare("t3");
    check("t3_lhold", {8'h0, l_data}, 32'h00BEEF00);

    // bclk stall mid left slot
    do_reset("t4");
    frame(24'h0F0F0F, 24'hF0F0F0, 32);
    send_slot(1'b0, 24'h333333, 0, 16);
    check("t4_lock_before", {31'h0, locked}, 32'h1);
    repeat (300) @(negedge clk);
    check("t4_lock_after", {31'h0, locked}, 32'h0);
    check("t4_stall_strobes", l_q.size() + r_q.size(), 32'd1);
    send_slot(1'b0, 24'h333333, 16, 32);
    send_slot(1'b1, 24'hCCCCCC, 0, 32);
    frame(24'h5A5A5A, 24'hC3C3C3, 32);
    close_and_flush();
    exp_r.push_back({1'b0, 24'hF0F0F0});
    exp_r.push_back({1'b0, 24'hCCCCCC});
    exp_r.push_back({1'b0, 24'hC3C3C3});
    exp_l.push_back({1'b0, 24'h5A5A5A});
    compare("t4");
    check("t4_rhold", {8'h0, r_data}, 32'h00C3C3C3);

    // reset pulse mid left slot
    do_reset("t5");
    frame(24'h0F0F0F, 24'hF0F0F0, 32);
    send_slot(1'b0, 24'h333333, 0, 16);
    check("t5_pre_rcnt", r_q.size(), 32'd1);
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_mid_l", {8'h0, l_data}, 32'h0);
    check("t5_mid_r", {8'h0, r_data}, 32'h0);
    check("t5_mid_ctl", {28'h0, l_data_valid, r_data_valid, frame_err, locked}, 32'h0);
    reset_n = 1'b1;
    send_slot(1'b0, 24'h333333, 16, 32);
    check("t5_unlocked", {31'h0, locked}, 32'h0);
    send_slot(1'b1, 24'hCCCCCC, 0, 32);
    frame(24'h5A5A5A, 24'hC3C3C3, 32);
    close_and_flush();
    exp_r.push_back({1'b0, 24'hF0F0F0});
    exp_r.push_back({1'b0, 24'hCCCCCC});
    exp_r.push_back({1'b0, 24'hC3C3C3});
    exp_l.push_back({1'b0, 24'h5A5A5A});
    compare("t5");

    // random data at 6.144 MHz, 32-bit slots
    do_reset("t6");
    for (int f = 0; f < 100; f++) begin
      rl[f] = 24'($urandom);
      rr[f] = 24'($urandom);
      frame(rl[f], rr[f], 32);
      exp_r.push_back({1'b0, rr[f]});
      if (f > 0) exp_l.push_back({1'b0, rl[f]});
    end
    close_and_flush();
    compare("t6");

    check("both_strobes", both_cnt, 32'd0);
    check("long_strobes", long_cnt, 32'd0);
    check("orphan_err", orphan_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
